grid_cursor_nav: RTL and testbench
==================================

Name: grid_cursor_nav

Overview:
- Parametrised cursor controller for the product selection grid of the sale terminal.
- Converts debounced direction-button input into a linear product index over a COLS x ROWS grid.
- Supports a legacy clamp mode and a toroidal wrap mode, hold-to-repeat movement, and a valid/ready select handshake toward the payment/vend logic.

Parameters:
- COLS, 4, grid columns (>=2).
- ROWS, 3, grid rows (>=2).
- ID_W, 4, index width; must satisfy 2^ID_W >= COLS*ROWS.
- REPEAT_DELAY, 500, cycles a direction must be held before the first auto-repeat step (>=2).
- REPEAT_RATE, 100, cycles between subsequent auto-repeat steps (>=1).

Ports:
- CLOCK  in  1  system clock; all state updates on the falling edge.
- RESET  in  1  synchronous, active-high reset.
- Enable  in  1  navigation enable; when low, no moves and the repeat FSM returns to IDLE.
- wrap_mode  in  1  0 = legacy clamp, 1 = toroidal wrap; sampled at each move.
- Dir_in  in  2  direction: 00 left, 01 up, 10 down, 11 right.
- dir_valid  in  1  level; high while a direction button is held.
- select_req  in  1  single-cycle confirm request.
- ProductID  out  ID_W  current cursor index, row-major, 0 = top-left.
- move_strobe  out  1  one-cycle pulse on every executed move, including a move that leaves the index unchanged.
- sel_valid  out  1  selected index available.
- sel_id  out  ID_W  index captured at select.
- sel_ready  in  1  consumer accepts sel_id.

Behaviour:
Reset:
- ProductID=0, sel_id=0, sel_valid=0, move_strobe=0, FSM=IDLE, counter=0.
- A reset mid-hold or while sel_valid is pending discards all state.

Definitions:
- N=COLS*ROWS, col=ProductID mod COLS, row=ProductID div COLS.
- All arithmetic is done at ID_W+1 bits before truncation; ProductID never leaves [0,N-1].

Move, wrap_mode=0 (legacy clamp):
- left: id>0 ? id-1 : 0.
- right: id<N-1 ? id+1 : N-1.
- up: id>=COLS ? id-COLS : 0.
- down: id<N-COLS ? id+COLS : N-1.

Move, wrap_mode=1 (toroidal):
- left: col=0 ? id+COLS-1 : id-1.
- right: col=COLS-1 ? id-COLS+1 : id+1.
- up: row=0 ? id+(ROWS-1)*COLS : id-COLS.
- down: row=ROWS-1 ? id-(ROWS-1)*COLS : id+COLS.

Repeat FSM (evaluated only when Enable=1):
- IDLE: dir_valid rising (previous sample 0) -> execute one move, latch dir, cnt=0, go to WAIT.
- WAIT: dir_valid=0 -> IDLE. Dir_in differs from latched dir -> execute a move in the new dir, relatch, cnt=0, stay in WAIT. cnt=REPEAT_DELAY-1 -> move, cnt=0, go to REPEAT. Otherwise cnt++.
- REPEAT: dir_valid=0 -> IDLE. Dir change -> move, relatch, cnt=0, go to WAIT. cnt=REPEAT_RATE-1 -> move, cnt=0. Otherwise cnt++.
- Latency: ProductID updates on the same edge that samples the rising dir_valid; move_strobe is high for exactly that cycle.
- Enable=0: FSM forced to IDLE and cnt=0; ProductID holds. The previous-dir_valid register keeps tracking, so a button already held when Enable rises does not move the cursor.

Select handshake:
- select_req=1 with sel_valid=0: sel_id<=ProductID (value before any same-cycle move), sel_valid<=1.
- sel_valid=1 and sel_ready=1: sel_valid<=0 next edge.
- select_req while sel_valid=1 is ignored, unless sel_ready=1 in that same cycle; then the new capture wins and sel_valid stays 1.
- sel_id stays stable while sel_valid=1. Cursor movement stays allowed while a select is pending.
- select_req is honoured regardless of Enable.

Optional Feature:
- Macro: GRID_NAV_AUTOREPEAT_EN.
- Defined: repeat FSM exactly as above.
- Undefined: WAIT/REPEAT and the counter are not built. One move per dir_valid rising edge only; a Dir_in change while held is ignored. REPEAT_DELAY and REPEAT_RATE are unused.

Test Plan:
- Reset then left press, wrap_mode=0 -> ProductID stays 0, move_strobe pulses once.
- wrap_mode=0, id=5, down, down -> 9, then 11 (clamp to N-1); up from 2 -> 0.
- wrap_mode=1, id=4, left -> 7; id=1, up -> 9; id=11, right -> 8; id=9, down -> 1.
- Macro defined, REPEAT_DELAY=4, REPEAT_RATE=2, hold right 10 cycles from id 0 -> moves at cycles 0, 4, 6, 8 -> final id 4; release -> IDLE.
- select_req at id 6 with sel_ready=0 for 5 cycles while moving to 7 -> sel_id=6 stable, sel_valid=1; sel_ready=1 -> sel_valid=0 next edge; back-to-back select_req with sel_ready=1 -> new id captured, sel_valid stays 1.
- RESET asserted mid-REPEAT with sel_valid=1 -> next edge all outputs 0, FSM IDLE; still-held button does not move until released and pressed again.

Source files
------------

// File: rtl/grid_cursor_nav.sv
// -----------------------------------------------------------------------------
// grid_cursor_nav
//
// Cursor controller for the product selection grid of the sale terminal.
// Turns debounced direction-button input into a row-major product index over
// a COLS x ROWS grid (0 = top-left), with a legacy clamp mode and a toroidal
// wrap mode, plus a valid/ready select handshake toward the payment/vend logic.
//
// All state updates on the falling edge of CLOCK; RESET is synchronous and
// active-high.
//
// Build option:
//   GRID_NAV_AUTOREPEAT_EN  defined   -> hold-to-repeat FSM (IDLE/WAIT/REPEAT)
//                                        driven by REPEAT_DELAY / REPEAT_RATE.
//                           undefined -> one move per dir_valid rising edge;
//                                        a direction change while held is
//                                        ignored and the repeat timing
//                                        parameters are unused.
//
// Ports:
//   CLOCK        in   system clock (falling-edge active)
//   RESET        in   synchronous active-high reset
//   Enable       in   navigation enable; low = no moves, repeat FSM to IDLE
//   wrap_mode    in   0 = clamp at grid edges, 1 = toroidal wrap
//   Dir_in       in   [1:0] 00 left, 01 up, 10 down, 11 right
//   dir_valid    in   high while a direction button is held
//   select_req   in   single-cycle confirm request
//   ProductID    out  [ID_W-1:0] current cursor index
//   move_strobe  out  one-cycle pulse per executed move (even a no-op move)
//   sel_valid    out  captured index available to the consumer
//   sel_id       out  [ID_W-1:0] index captured at select
//   sel_ready    in   consumer accepts sel_id
// -----------------------------------------------------------------------------
module grid_cursor_nav #(
  parameter int COLS         = 4,
  parameter int ROWS         = 3,
  parameter int ID_W         = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            Enable,
  input  logic            wrap_mode,
  input  logic [1:0]      Dir_in,
  input  logic            dir_valid,
  input  logic            select_req,
  output logic [ID_W-1:0] ProductID,
  output logic            move_strobe,
  output logic            sel_valid,
  output logic [ID_W-1:0] sel_id,
  input  logic            sel_ready
);

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // One spare bit so id+COLS etc. never overflow before the range fix-up.
  typedef logic [ID_W:0] wide_t;

  localparam wide_t C_W     = wide_t'(COLS);
  localparam wide_t N_W     = wide_t'(COLS * ROWS);
  localparam wide_t LAST_ID = wide_t'(COLS * ROWS - 1);
  localparam wide_t LAST_C  = wide_t'(COLS - 1);
  localparam wide_t LAST_R  = wide_t'(ROWS - 1);
  localparam wide_t ROW_OFS = wide_t'((ROWS - 1) * COLS);

  function automatic logic [ID_W-1:0] step_id(input logic [ID_W-1:0] id,
                                               input dir_t            dir,
                                               input logic            wrap);
    wide_t w;
    wide_t col;
    wide_t row;
    wide_t r;
    w   = {1'b0, id};
    col = w % C_W;
    row = w / C_W;
    r   = w;
    if (!wrap) begin
      case (dir)
        DIR_LEFT:  r = (w > '0)          ? w - wide_t'(1) : '0;
        DIR_RIGHT: r = (w < LAST_ID)     ? w + wide_t'(1) : LAST_ID;
        DIR_UP:    r = (w >= C_W)        ? w - C_W        : '0;
        DIR_DOWN:  r = (w < N_W - C_W)   ? w + C_W        : LAST_ID;
        default:   r = w;
      endcase
    end else begin
      case (dir)
        DIR_LEFT:  r = (col == '0)     ? w + LAST_C        : w - wide_t'(1);
        DIR_RIGHT: r = (col == LAST_C) ? w - LAST_C        : w + wide_t'(1);
        DIR_UP:    r = (row == '0)     ? w + ROW_OFS       : w - C_W;
        DIR_DOWN:  r = (row == LAST_R) ? w - ROW_OFS       : w + C_W;
        default:   r = w;
      endcase
    end
    return ID_W'(r);
  endfunction

  logic [ID_W-1:0] next_id;
  logic            prev_valid;

  assign next_id = step_id(ProductID, dir_t'(Dir_in), wrap_mode);

`ifdef GRID_NAV_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  state_t           state;
  dir_t             dir_q;
  logic [CNT_W-1:0] cnt;
`else
  // Timing parameters only matter to the repeat FSM.
  logic unused_cfg;
  assign unused_cfg = (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
`endif

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of one another, exactly like the flops they describe.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      // NOTE: only registers whose value carries meaning are reset; prev_valid
      // keeps following the button so a key held through reset stays inert.
      ProductID   <= '0;
      move_strobe <= 1'b0;
      sel_valid   <= 1'b0;
      sel_id      <= '0;
      prev_valid  <= dir_valid;
`ifdef GRID_NAV_AUTOREPEAT_EN
      state       <= ST_IDLE;
      dir_q       <= DIR_LEFT;
      cnt         <= '0;
`endif
    end else begin
      prev_valid  <= dir_valid;
      move_strobe <= 1'b0;

`ifdef GRID_NAV_AUTOREPEAT_EN
      if (!Enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dir_valid && !prev_valid) begin
              ProductID   <= next_id;
              move_strobe <= 1'b1;
              dir_q       <= dir_t'(Dir_in);
              cnt         <= '0;
              state       <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!dir_valid) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (Dir_in != dir_q) begin
              // New direction restarts the initial hold delay.
              ProductID   <= next_id;
              move_strobe <= 1'b1;
              dir_q       <= dir_t'(Dir_in);
              cnt         <= '0;
            end else if (cnt == DELAY_LAST) begin
              ProductID   <= next_id;
              move_strobe <= 1'b1;
              cnt         <= '0;
              state       <= ST_REPEAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!dir_valid) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (Dir_in != dir_q) begin
              ProductID   <= next_id;
              move_strobe <= 1'b1;
              dir_q       <= dir_t'(Dir_in);
              cnt         <= '0;
              state       <= ST_WAIT;
            end else if (cnt == RATE_LAST) begin
              ProductID   <= next_id;
              move_strobe <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
`else
      if (Enable && dir_valid && !prev_valid) begin
        ProductID   <= next_id;
        move_strobe <= 1'b1;
      end
`endif

      // Capture uses the pre-move ProductID; a consumer accepting in the same
      // cycle frees the slot, so the new request overwrites and stays valid.
      if (select_req && (!sel_valid || sel_ready)) begin
        sel_id    <= ProductID;
        sel_valid <= 1'b1;
      end else if (sel_valid && sel_ready) begin
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor_nav.sv
// -----------------------------------------------------------------------------
// tb_grid_cursor_nav
//
// Directed self-checking bench for grid_cursor_nav on a 4x3 grid with
// REPEAT_DELAY=4 and REPEAT_RATE=2. Inputs change 1 time unit after a falling
// edge and outputs are checked 1 time unit after the following falling edge.
// Expected values for the hold-to-repeat steps follow GRID_NAV_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_grid_cursor_nav;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int ID_W = 4;

  logic            CLOCK;
  logic            RESET;
  logic            Enable;
  logic            wrap_mode;
  logic [1:0]      Dir_in;
  logic            dir_valid;
  logic            select_req;
  logic [ID_W-1:0] ProductID;
  logic            move_strobe;
  logic            sel_valid;
  logic [ID_W-1:0] sel_id;
  logic            sel_ready;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] L = 2'b00;
  localparam logic [1:0] U = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] R = 2'b11;

  grid_cursor_nav #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .ID_W        (ID_W),
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .Enable     (Enable),
    .wrap_mode  (wrap_mode),
    .Dir_in     (Dir_in),
    .dir_valid  (dir_valid),
    .select_req (select_req),
    .ProductID  (ProductID),
    .move_strobe(move_strobe),
    .sel_valid  (sel_valid),
    .sel_id     (sel_id),
    .sel_ready  (sel_ready)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one active (falling) edge and settle just past it.
  task automatic tick();
    @(negedge CLOCK);
    #1;
  endtask

  // Single press-and-release: move on the press edge, idle on release edge.
  task automatic press(input logic [1:0] dir);
    Dir_in    = dir;
    dir_valid = 1'b1;
    tick();
    dir_valid = 1'b0;
    tick();
  endtask

  int strobes;
  int exp_hold_id;
  int exp_hold_strobes;

  initial begin
    RESET      = 1'b1;
    Enable     = 1'b1;
    wrap_mode  = 1'b0;
    Dir_in     = L;
    dir_valid  = 1'b0;
    select_req = 1'b0;
    sel_ready  = 1'b0;
    #1;
    tick();
    tick();
    check("reset_id",     ProductID,   0);
    check("reset_strobe", move_strobe, 0);
    check("reset_valid",  sel_valid,   0);
    check("reset_sel_id", sel_id,      0);
    RESET = 1'b0;

    // Left at id 0 in clamp mode: no index change but the move still strobes.
    Dir_in = L; dir_valid = 1'b1;
    tick();
    check("left_at_0_id",     ProductID,   0);
    check("left_at_0_strobe", move_strobe, 1);
    dir_valid = 1'b0;
    tick();
    check("strobe_one_cycle", move_strobe, 0);

    // Clamp mode: 0 -> 1 -> 5, then down twice hits the bottom clamp.
    press(R);
    press(D);
    check("clamp_reach_5", ProductID, 5);
    press(D);
    check("clamp_down_5_9", ProductID, 9);
    press(D);
    check("clamp_down_9_11", ProductID, 11);
    press(U); press(U); press(L);
    check("clamp_reach_2", ProductID, 2);
    press(U);
    check("clamp_up_2_0", ProductID, 0);

    // Wrap mode.
    wrap_mode = 1'b1;
    press(D);
    check("wrap_reach_4", ProductID, 4);
    press(L);
    check("wrap_left_4_7", ProductID, 7);
    press(U); press(L); press(L);
    check("wrap_reach_1", ProductID, 1);
    press(U);
    check("wrap_up_1_9", ProductID, 9);
    press(R); press(R);
    check("wrap_reach_11", ProductID, 11);
    press(R);
    check("wrap_right_11_8", ProductID, 8);
    press(R);
    check("wrap_right_8_9", ProductID, 9);
    press(D);
    check("wrap_down_9_1", ProductID, 1);

    // Hold right for 10 edges from id 0 in clamp mode.
    wrap_mode = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_before_hold", ProductID, 0);
`ifdef GRID_NAV_AUTOREPEAT_EN
    exp_hold_id      = 4;
    exp_hold_strobes = 4;
`else
    exp_hold_id      = 1;
    exp_hold_strobes = 1;
`endif
    strobes   = 0;
    Dir_in    = R;
    dir_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (move_strobe === 1'b1) strobes++;
    end
    check("hold_id",      ProductID, exp_hold_id);
    check("hold_strobes", strobes,   exp_hold_strobes);
    dir_valid = 1'b0;
    tick();
    check("hold_release_id",     ProductID,   exp_hold_id);
    check("hold_release_strobe", move_strobe, 0);

    // Enable low blocks moves; a button already held when Enable rises is inert.
    Enable = 1'b0;
    Dir_in = L; dir_valid = 1'b1;
    tick();
    check("disabled_no_move", move_strobe, 0);
    Enable = 1'b1;
    tick(); tick();
    check("enable_held_no_move", ProductID, exp_hold_id);
    dir_valid = 1'b0;
    tick();

    // Bring cursor to 6 (clamp mode).
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    press(D); press(R); press(R);
    check("sel_reach_6", ProductID, 6);

    // Capture 6 while moving to 7 in the same cycle; consumer stalls.
    select_req = 1'b1; sel_ready = 1'b0; Dir_in = R; dir_valid = 1'b1;
    tick();
    check("sel_cap_id",    sel_id,    6);
    check("sel_cap_valid", sel_valid, 1);
    check("sel_moved_7",   ProductID, 7);
    select_req = 1'b0; dir_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    select_req = 1'b1;
    tick();
    select_req = 1'b0;
    check("sel_stall_id",    sel_id,    6);
    check("sel_stall_valid", sel_valid, 1);
    sel_ready = 1'b1;
    tick();
    check("sel_accept_valid", sel_valid, 0);

    // Back-to-back selects with the consumer ready.
    select_req = 1'b1; Dir_in = R; dir_valid = 1'b1;
    tick();
    check("b2b_first_id", sel_id,    7);
    check("b2b_moved_8",  ProductID, 8);
    dir_valid = 1'b0;
    tick();
    check("b2b_second_id",    sel_id,    8);
    check("b2b_second_valid", sel_valid, 1);
    select_req = 1'b0;
    tick();
    check("b2b_drain_valid", sel_valid, 0);

    // Reset mid-hold with a pending select, button kept held through it.
    sel_ready = 1'b0; select_req = 1'b1;
    tick();
    select_req = 1'b0;
    check("pre_rst_valid", sel_valid, 1);
    Dir_in = R; dir_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    RESET = 1'b1;
    tick();
    check("midrst_id",     ProductID,   0);
    check("midrst_strobe", move_strobe, 0);
    check("midrst_valid",  sel_valid,   0);
    check("midrst_sel_id", sel_id,      0);
    RESET = 1'b0;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (move_strobe === 1'b1) strobes++;
    end
    check("held_after_rst_id",      ProductID, 0);
    check("held_after_rst_strobes", strobes,   0);
    dir_valid = 1'b0;
    tick();
    dir_valid = 1'b1;
    tick();
    check("repress_id",     ProductID,   1);
    check("repress_strobe", move_strobe, 1);
    dir_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
